// File: rtl/vga_pix_pipe_if.sv
// rtl/vga_pix_pipe_if.sv - frame-buffer read port between the pixel pipe and memory
interface vga_pix_pipe_if #(
    parameter int AW = 19,
    parameter int CW = 4
) ();
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [3*CW-1:0]   pix_data;

    modport master (
        output rd_en,
        output rd_addr,
        input  pix_data
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output pix_data
    );
endinterface

// File: rtl/vga_pix_pipe.sv
// rtl/vga_pix_pipe.sv - VGA display-data pipeline: coordinates, frame-buffer address, delay-matched RGB/syncs
module vga_pix_pipe #(
    parameter int H_RES  = 800,
    parameter int V_RES  = 600,
    parameter int RD_LAT = 2,
    parameter int SHIFT  = 0,
    parameter int AW     = 19,
    parameter int CW     = 4
) (
    input  logic               clk_px,
    input  logic               rst_n,
    input  logic               hen,
    input  logic               ven,
    input  logic               hs,
    input  logic               vs,
    vga_pix_pipe_if.master     fb,
    output logic [10:0]        pix_x,
    output logic [9:0]         pix_y,
    output logic               frame_sof,
    output logic [3*CW-1:0]    vga_rgb,
    output logic               vga_hs,
    output logic               vga_vs
);
    localparam logic [10:0] X_MAX = 11'(H_RES - 1);
    localparam logic [9:0]  Y_MAX = 10'(V_RES - 1);
    localparam int          H_BLK = H_RES >> SHIFT;

    logic [10:0]     cx;
    logic [9:0]      cy;
    logic            hen_d;
    logic            sync_ok;
    logic            de;
    logic [AW-1:0]   addr_nxt;
    logic [RD_LAT:0] de_sr;
    logic [RD_LAT:0] hs_sr;
    logic [RD_LAT:0] vs_sr;

    // sync_ok stays low until a vertical blank is seen, so a reset released
    // mid-frame never emits pixels with misaligned coordinates.
    assign de       = hen & ven & sync_ok;
    assign addr_nxt = AW'(32'(cy >> SHIFT) * H_BLK) + AW'(cx >> SHIFT);

    always_ff @(posedge clk_px) begin
        if (!rst_n) begin
            cx         <= '0;
            cy         <= '0;
            hen_d      <= 1'b0;
            sync_ok    <= 1'b0;
            fb.rd_en   <= 1'b0;
            fb.rd_addr <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            frame_sof  <= 1'b0;
            de_sr      <= '0;
            hs_sr      <= '0;
            vs_sr      <= '0;
            vga_rgb    <= '0;
            vga_hs     <= 1'b0;
            vga_vs     <= 1'b0;
        end else begin
            hen_d <= hen;
            if (!ven) begin
                sync_ok <= 1'b1;
            end

            if (!hen) begin
                cx <= '0;
            end else if (de && cx != X_MAX) begin
                cx <= cx + 11'd1;
            end

            // Blanking clears the line counter even on a falling-hen cycle.
            if (!ven) begin
                cy <= '0;
            end else if (hen_d && !hen && cy != Y_MAX) begin
                cy <= cy + 10'd1;
            end

            fb.rd_en  <= de;
            frame_sof <= de && cx == 11'd0 && cy == 10'd0;
            if (de) begin
                pix_x      <= cx;
                pix_y      <= cy;
                fb.rd_addr <= addr_nxt;
            end

            // RD_LAT+1 stages: one for the address register, RD_LAT for memory.
            de_sr <= {de_sr[RD_LAT-1:0], de};
            hs_sr <= {hs_sr[RD_LAT-1:0], hs};
            vs_sr <= {vs_sr[RD_LAT-1:0], vs};

            vga_rgb <= de_sr[RD_LAT] ? fb.pix_data : '0;
            vga_hs  <= hs_sr[RD_LAT];
            vga_vs  <= vs_sr[RD_LAT];
        end
    end
endmodule

// File: tb/tb_vga_pix_pipe.sv
// tb/tb_vga_pix_pipe.sv - scoreboard bench for vga_pix_pipe at reduced resolution, SHIFT=0 and SHIFT=1
module tb_vga_pix_pipe;
    localparam int H_RES  = 16;
    localparam int V_RES  = 6;
    localparam int RD_LAT = 2;
    localparam int AW     = 7;
    localparam int CW     = 4;

    logic clk_px = 1'b0;
    logic rst_n  = 1'b0;
    logic hen = 1'b0, ven = 1'b0, hs = 1'b0, vs = 1'b0;
    logic force_fff = 1'b0;

    logic [10:0]     pix_x0, pix_x1;
    logic [9:0]      pix_y0, pix_y1;
    logic            sof0, sof1;
    logic [3*CW-1:0] rgb0, rgb1;
    logic            vhs0, vvs0, vhs1, vvs1;

    vga_pix_pipe_if #(.AW(AW), .CW(CW)) fb0 ();
    vga_pix_pipe_if #(.AW(AW), .CW(CW)) fb1 ();

    vga_pix_pipe #(.H_RES(H_RES), .V_RES(V_RES), .RD_LAT(RD_LAT), .SHIFT(0), .AW(AW), .CW(CW)) u_dut0 (
        .clk_px(clk_px), .rst_n(rst_n), .hen(hen), .ven(ven), .hs(hs), .vs(vs),
        .fb(fb0), .pix_x(pix_x0), .pix_y(pix_y0), .frame_sof(sof0),
        .vga_rgb(rgb0), .vga_hs(vhs0), .vga_vs(vvs0));

    vga_pix_pipe #(.H_RES(H_RES), .V_RES(V_RES), .RD_LAT(RD_LAT), .SHIFT(1), .AW(AW), .CW(CW)) u_dut1 (
        .clk_px(clk_px), .rst_n(rst_n), .hen(hen), .ven(ven), .hs(hs), .vs(vs),
        .fb(fb1), .pix_x(pix_x1), .pix_y(pix_y1), .frame_sof(sof1),
        .vga_rgb(rgb1), .vga_hs(vhs1), .vga_vs(vvs1));

    always #5 clk_px = ~clk_px;

    function automatic logic [11:0] mem_val(input logic [6:0] a);
        return {a[3:0] ^ 4'hA, a[6:3] + 4'h3, ~a[3:0]};
    endfunction

    // Frame-buffer model with a two-cycle read latency.
    logic [6:0] ma0, ma1;
    always @(posedge clk_px) begin
        ma0 <= fb0.rd_addr;
        ma1 <= ma0;
    end
    assign fb0.pix_data = force_fff ? 12'hFFF : mem_val(ma1);
    assign fb1.pix_data = 12'h000;

    typedef struct {
        logic        en;
        logic [10:0] x;
        logic [9:0]  y;
        logic [6:0]  a0;
        logic [6:0]  a1;
        logic        sof;
    } rd_t;

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } out_t;

    rd_t  rdq[$];
    out_t outq[$];

    int nchk = 0;
    int nerr = 0;
    logic sync_m = 1'b0;
    int last_x = 0, last_y = 0, last_a0 = 0, last_a1 = 0;
    int n_rd = 0, n_sof = 0, last_addr = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input logic h, input logic v, input logic hsv, input logic vsv,
                        input int col, input int line);
        rd_t  r;
        out_t o;
        logic de;
        int   xe, ye;
        de = h & v & sync_m;
        xe = (col > H_RES - 1) ? H_RES - 1 : col;
        ye = (line > V_RES - 1) ? V_RES - 1 : line;
        if (de) begin
            last_x  = xe;
            last_y  = ye;
            last_a0 = ye * H_RES + xe;
            last_a1 = (ye >> 1) * (H_RES >> 1) + (xe >> 1);
        end
        r.en  = de;
        r.x   = 11'(last_x);
        r.y   = 10'(last_y);
        r.a0  = 7'(last_a0);
        r.a1  = 7'(last_a1);
        r.sof = de && xe == 0 && ye == 0;
        rdq.push_back(r);
        o.rgb = de ? (force_fff ? 12'hFFF : mem_val(7'(last_a0))) : 12'h000;
        o.hs  = hsv;
        o.vs  = vsv;
        outq.push_back(o);
        if (!v) sync_m = 1'b1;

        hen = h; ven = v; hs = hsv; vs = vsv;
        @(negedge clk_px);

        r = rdq.pop_front();
        chk("rd_en",     32'(fb0.rd_en),   32'(r.en));
        chk("pix_x",     32'(pix_x0),      32'(r.x));
        chk("pix_y",     32'(pix_y0),      32'(r.y));
        chk("rd_addr",   32'(fb0.rd_addr), 32'(r.a0));
        chk("frame_sof", 32'(sof0),        32'(r.sof));
        chk("rd_en_s1",  32'(fb1.rd_en),   32'(r.en));
        chk("rd_addr_s1", 32'(fb1.rd_addr), 32'(r.a1));
        if (fb0.rd_en) begin
            n_rd++;
            last_addr = int'(fb0.rd_addr);
        end
        if (sof0) n_sof++;

        if (outq.size() >= 4) begin
            o = outq.pop_front();
            chk("vga_rgb",   32'(rgb0), 32'(o.rgb));
            chk("vga_hs",    32'(vhs0), 32'(o.hs));
            chk("vga_vs",    32'(vvs0), 32'(o.vs));
            chk("vga_hs_s1", 32'(vhs1), 32'(o.hs));
            chk("vga_vs_s1", 32'(vvs1), 32'(o.vs));
        end
    endtask

    task automatic do_reset(input logic h, input logic v);
        out_t z;
        rst_n = 1'b0;
        hen = h; ven = v; hs = 1'b0; vs = 1'b0;
        repeat (3) @(negedge clk_px);
        chk("rst_rd_en",   32'(fb0.rd_en),   0);
        chk("rst_rd_addr", 32'(fb0.rd_addr), 0);
        chk("rst_pix_x",   32'(pix_x0),      0);
        chk("rst_pix_y",   32'(pix_y0),      0);
        chk("rst_sof",     32'(sof0),        0);
        chk("rst_rgb",     32'(rgb0),        0);
        chk("rst_hs",      32'(vhs0),        0);
        chk("rst_vs",      32'(vvs0),        0);
        chk("rst_rd_addr_s1", 32'(fb1.rd_addr), 0);
        rst_n = 1'b1;
        rdq.delete();
        outq.delete();
        z.rgb = 12'h000; z.hs = 1'b0; z.vs = 1'b0;
        repeat (3) outq.push_back(z);
        sync_m  = 1'b0;
        last_x  = 0; last_y = 0; last_a0 = 0; last_a1 = 0;
    endtask

    task automatic frame(input int first_line, input int n_act, input int stretch_line,
                         input int stop_after, input int exp_rd, input int exp_sof,
                         input int exp_last);
        int hl;
        int nt;
        nt = 0;
        n_rd = 0; n_sof = 0; last_addr = -1;
        for (int l = first_line; l < n_act + 3; l++) begin
            hl = (l == stretch_line) ? H_RES + 10 : H_RES;
            for (int c = 0; c < hl + 8; c++) begin
                tick(c < hl, l < n_act, c >= hl + 2 && c < hl + 5, l == n_act + 1, c, l);
                nt++;
                if (stop_after > 0 && nt == stop_after) return;
            end
        end
        chk("frame_rd_count",  n_rd,  exp_rd);
        chk("frame_sof_count", n_sof, exp_sof);
        if (exp_last >= 0) chk("frame_last_addr", last_addr, exp_last);
    endtask

    initial begin
        do_reset(1'b1, 1'b1);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        frame(0, V_RES, -1, 0, H_RES * V_RES, 1, H_RES * V_RES - 1);
        frame(0, V_RES, 3, 0, H_RES * V_RES + 10, 1, H_RES * V_RES - 1);
        frame(0, V_RES + 2, -1, 0, H_RES * (V_RES + 2), 1, H_RES * V_RES - 1);
        force_fff = 1'b1;
        frame(0, V_RES, -1, 0, H_RES * V_RES, 1, H_RES * V_RES - 1);
        force_fff = 1'b0;
        frame(0, V_RES, -1, (H_RES + 8) * 2 + 8, 0, 0, -1);
        do_reset(1'b1, 1'b1);
        frame(2, V_RES, -1, 0, 0, 0, -1);
        frame(0, V_RES, -1, 0, H_RES * V_RES, 1, H_RES * V_RES - 1);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
